// File: rtl/picosoc_iomux.sv
// picosoc_iomux: decoded I/O fabric for the PicoSoC iomem bus.
// Splits the CPU-side iomem port into NUM_PORTS windowed peripheral ports,
// registers each request, allows one outstanding transaction and turns
// unmapped accesses or stalled slaves into error responses.
// Optional build macro: PICOSOC_IOMUX_WPROT_EN (per-port write protection
// through WPROT_MASK; writes to a protected port are answered as unmapped).
module picosoc_iomux #(
  parameter int                   NUM_PORTS   = 4,
  parameter logic [31:0]          BASE_ADDR   = 32'h0300_0000,
  parameter int                   PORT_AWIDTH = 8,
  parameter int                   TIMEOUT     = 255,
  parameter logic [31:0]          ERR_RDATA   = 32'hFFFF_FFFF,
  parameter logic [NUM_PORTS-1:0] WPROT_MASK  = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wstrb,
  output logic [31:0]             mem_rdata,
  output logic [NUM_PORTS-1:0]    p_valid,
  input  logic [NUM_PORTS-1:0]    p_ready,
  output logic [31:0]             p_addr,
  output logic [31:0]             p_wdata,
  output logic [3:0]              p_wstrb,
  input  logic [32*NUM_PORTS-1:0] p_rdata,
  output logic                    err_irq,
  output logic [31:0]             err_addr
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int UW = 32 - PORT_AWIDTH;
  localparam logic [UW-1:0] BASE_HI = BASE_ADDR[31:PORT_AWIDTH];
  localparam logic [15:0]   TMO     = 16'(TIMEOUT);

`ifdef PICOSOC_IOMUX_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_PORTS-1:0] p_valid_q, p_valid_d;
  logic [31:0]          p_addr_q, p_addr_d;
  logic [31:0]          p_wdata_q, p_wdata_d;
  logic [3:0]           p_wstrb_q, p_wstrb_d;
  logic [PW-1:0]        sel_q, sel_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 mem_ready_q, mem_ready_d;
  logic [31:0]          mem_rdata_q, mem_rdata_d;
  logic                 err_irq_q, err_irq_d;
  logic [31:0]          err_addr_q, err_addr_d;

  logic                 hit;
  logic [PW-1:0]        hit_idx;
  logic                 wp_block;
  logic [31:0]          rd_arr [NUM_PORTS];

  // Unpack the flat read-data bus so the selected slice can be indexed.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
    assign rd_arr[g] = p_rdata[32*g +: 32];
  end

  // Window decode: port i owns the 2^PORT_AWIDTH block at BASE_ADDR + i*size.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mem_addr[31:PORT_AWIDTH] == BASE_HI + UW'(i)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // Writes to a protected port are refused before reaching the slave.
  assign wp_block = WPROT_EN && (mem_wstrb != 4'b0000) && WPROT_MASK[hit_idx];

  // Next-state logic: IDLE decodes, REQ waits for ready or timeout, RESP acks.
  always_comb begin
    state_d     = state_q;
    p_valid_d   = p_valid_q;
    p_addr_d    = p_addr_q;
    p_wdata_d   = p_wdata_q;
    p_wstrb_d   = p_wstrb_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = '0;
    err_irq_d   = 1'b0;
    err_addr_d  = err_addr_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          if (hit && !wp_block) begin
            p_addr_d  = mem_addr;
            p_wdata_d = mem_wdata;
            p_wstrb_d = mem_wstrb;
            p_valid_d = NUM_PORTS'(1) << hit_idx;
            sel_d     = hit_idx;
            cnt_d     = '0;
            state_d   = S_REQ;
          end else begin
            // Unmapped or refused: answer directly, nothing reaches a slave.
            state_d     = S_RESP;
            mem_ready_d = 1'b1;
            mem_rdata_d = ERR_RDATA;
            err_irq_d   = 1'b1;
            err_addr_d  = mem_addr;
          end
        end
      end
      S_REQ: begin
        if (p_ready[sel_q]) begin
          // Ready beats a coincident timeout.
          p_valid_d   = '0;
          state_d     = S_RESP;
          mem_ready_d = 1'b1;
          mem_rdata_d = rd_arr[sel_q];
        end else if (TIMEOUT != 0 && cnt_q == TMO) begin
          p_valid_d   = '0;
          state_d     = S_RESP;
          mem_ready_d = 1'b1;
          mem_rdata_d = ERR_RDATA;
          err_irq_d   = 1'b1;
          err_addr_d  = p_addr_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any slave access immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      p_valid_q   <= '0;
      p_addr_q    <= '0;
      p_wdata_q   <= '0;
      p_wstrb_q   <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      err_irq_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      p_valid_q   <= p_valid_d;
      p_addr_q    <= p_addr_d;
      p_wdata_q   <= p_wdata_d;
      p_wstrb_q   <= p_wstrb_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      err_irq_q   <= err_irq_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign p_valid   = p_valid_q;
  assign p_addr    = p_addr_q;
  assign p_wdata   = p_wdata_q;
  assign p_wstrb   = p_wstrb_q;
  assign err_irq   = err_irq_q;
  assign err_addr  = err_addr_q;

endmodule

// File: doc/picosoc_iomux.md
Name: picosoc_iomux

Overview:
- Parametrised I/O fabric for the PicoSoC native memory bus. It replaces the single pass-through iomem port with NUM_PORTS decoded peripheral ports.
- Sits between the CPU-side iomem interface (address space 0x0300_0000 and up) and external peripherals.
- Registers each request and enforces one outstanding transaction.
- Answers unmapped accesses and unresponsive slaves with an error response, an interrupt pulse and a captured fault address, so the CPU never hangs.

Parameters:
- NUM_PORTS, 4: number of peripheral ports, legal range 1..16.
- BASE_ADDR, 32'h0300_0000: start of port 0's window. Must be aligned to 2^PORT_AWIDTH.
- PORT_AWIDTH, 8: log2 of window size in bytes. Port i occupies BASE_ADDR + i*2^PORT_AWIDTH.
- TIMEOUT, 255: maximum number of cycles p_valid stays high without p_ready. 0 disables the timeout. Maximum 65535.
- ERR_RDATA, 32'hFFFF_FFFF: mem_rdata value returned on any error response.
- WPROT_MASK, 0: per-port write-protect bits (NUM_PORTS wide). Used only with the optional feature.

Ports:
- clk  in  1  system clock, all state on the rising edge
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  CPU request valid; held until mem_ready
- mem_ready  out  1  one-cycle acknowledge
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 means read
- mem_rdata  out  32  read data, valid while mem_ready=1
- p_valid  out  NUM_PORTS  one-hot port request
- p_ready  in  NUM_PORTS  port acknowledge
- p_addr  out  32  registered request address, shared by all ports
- p_wdata  out  32  registered write data, shared
- p_wstrb  out  4  registered strobes, shared
- p_rdata  in  32*NUM_PORTS  port i read data on bits [32*i+31:32*i]
- err_irq  out  1  one-cycle pulse per error response
- err_addr  out  32  address of the most recent error

Behaviour:
- Reset (async, resetn=0): state IDLE. mem_ready=0, mem_rdata=0, p_valid=0, p_addr/p_wdata/p_wstrb=0, err_irq=0, err_addr=0, timeout counter=0. p_valid drops immediately, including mid-transaction. The aborted slave access is not retried.
- FSM state IDLE: on mem_valid=1 at a clock edge, decode mem_addr.
  - Hit port i (mem_addr[31:PORT_AWIDTH] == BASE_ADDR[31:PORT_AWIDTH]+i, i<NUM_PORTS): register addr/wdata/wstrb, set p_valid[i]=1, clear counter, go to REQ.
  - No hit: go to RESP with error.
- FSM state REQ: p_valid held and p_* stable.
  - p_ready[i]=1 at an edge: capture p_rdata slice i, drop p_valid, go to RESP (normal).
  - Otherwise the counter increments. When the counter reaches TIMEOUT (TIMEOUT!=0), drop p_valid and go to RESP with error.
  - If p_ready and the timeout occur on the same edge, p_ready wins: normal response.
  - p_ready on non-selected ports is ignored.
- FSM state RESP: mem_ready=1 for exactly one cycle, then go to IDLE.
  - Normal response: mem_rdata = captured data. Writes return captured data as well; the CPU ignores it.
  - Error response: mem_rdata = ERR_RDATA, err_irq=1 in this same cycle, err_addr updated to the faulting mem_addr.
  - mem_rdata returns to 0 when mem_ready=0.
- Latency: mem_valid seen in cycle N; p_valid high in N+1; with zero-wait p_ready in N+1, mem_ready is high in N+2.
  - Unmapped access: mem_ready in N+1.
  - Timeout: mem_ready in N+1+TIMEOUT+1.
- IDLE accepts a new request in the cycle immediately after RESP.
- mem_valid dropping mid-transaction is illegal. The block completes the transaction regardless.
- Writes to unmapped addresses are discarded, not forwarded, and reported as errors.

Optional Feature:
- Macro: PICOSOC_IOMUX_WPROT_EN.
- Defined: a write (mem_wstrb!=0) to port i with WPROT_MASK[i]=1 is not forwarded (p_valid stays 0) and is answered as an unmapped access: RESP in N+1, ERR_RDATA, err_irq, err_addr. Reads from protected ports proceed normally.
- Undefined: WPROT_MASK is ignored and all writes are forwarded.

Test Plan:
- Zero-wait read: read 0x0300_0104, p_ready[1] tied 1, p_rdata slice 1 = 0x1234_5678 -> p_valid=4'b0010 for 1 cycle, p_addr=0x0300_0104, mem_ready at N+2 with mem_rdata=0x1234_5678, err_irq=0.
- Wait-state write: write 0xCAFE_0001, wstrb=4'b0011, to 0x0300_0208; slave asserts ready after 3 cycles -> p_wdata/p_wstrb stable for 4 cycles, mem_ready at N+5, no error.
- Unmapped read: read 0x0300_0400 (NUM_PORTS=4) -> no p_valid, mem_ready at N+1, mem_rdata=0xFFFF_FFFF, err_irq pulse, err_addr=0x0300_0400.
- Timeout: TIMEOUT=4, port 3 never ready -> p_valid[3] high 5 cycles, then mem_ready with ERR_RDATA, err_addr=0x0300_0300. Then a back-to-back read of port 0 completes normally.
- Reset mid-REQ: resetn low while p_valid[2]=1 -> p_valid=0 and err_addr=0 immediately (before the next clk edge), mem_ready=0. After release, a new request completes normally.
- WPROT (macro defined, WPROT_MASK=4'b0100): write to 0x0300_0200 -> no p_valid, error response at N+1. A read of the same address returns slave data.
